// File: rtl/tug_game_ctrl_if.sv
// Tug-of-war controller bus: player keys in, playfield/score display out.
//   key_l, key_r : raw player keys (asynchronous to clk, 1 = pressed)
//   leds         : one-hot rope position, bit NLIGHTS-1 is leftmost; all 0 outside play
//   score_l/r    : round wins per player
//   winner       : last round winner, 2'b10 = left, 2'b01 = right, 2'b00 = none
//   game_over    : high once either score reaches the game target
// master = controller side, slave = board/driver side.
interface tug_game_ctrl_if #(
  parameter int unsigned NLIGHTS = 9,
  parameter int unsigned SCORE_W = 3
);
  logic               key_l;
  logic               key_r;
  logic [NLIGHTS-1:0] leds;
  logic [SCORE_W-1:0] score_l;
  logic [SCORE_W-1:0] score_r;
  logic [1:0]         winner;
  logic               game_over;

  modport master (
    input  key_l, key_r,
    output leds, score_l, score_r, winner, game_over
  );

  modport slave (
    output key_l, key_r,
    input  leds, score_l, score_r, winner, game_over
  );
endinterface

// File: rtl/tug_game_ctrl.sv
// Central round/score controller for the tug-of-war playfield.
// Conditions both raw keys into one-cycle press events, moves the rope, detects round
// wins, keeps scores and sequences win display, next-round restart and game over.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : tug_game_ctrl_if master (keys in; leds, scores, winner, game_over out)
module tug_game_ctrl #(
  parameter int unsigned NLIGHTS     = 9,
  parameter int unsigned SCORE_MAX   = 7,
  parameter int unsigned SCORE_W     = 3,
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic            clk,
  input  logic            reset,
  tug_game_ctrl_if.master bus
);

  localparam int unsigned PosW = $clog2(NLIGHTS);
  localparam int unsigned CntW = $clog2(HOLD_CYCLES + 1);

  localparam logic [PosW-1:0]    PosMax   = PosW'(NLIGHTS - 1);
  localparam logic [PosW-1:0]    PosCtr   = PosW'((NLIGHTS - 1) / 2);
  localparam logic [CntW-1:0]    HoldLast = CntW'(HOLD_CYCLES - 1);
  localparam logic [SCORE_W-1:0] ScoreMax = SCORE_W'(SCORE_MAX);

  typedef enum logic [1:0] {
    StPlay,
    StWinHold,
    StOver
  } state_e;

  // Key conditioning; bit 1 = left key, bit 0 = right key.
  logic [1:0] s1_q, s2_q, prev_q;
  logic       press_l, press_r;

  state_e             state_q, state_d;
  logic [PosW-1:0]    pos_q, pos_d;
  logic [SCORE_W-1:0] score_l_q, score_l_d;
  logic [SCORE_W-1:0] score_r_q, score_r_d;
  logic [1:0]         winner_q, winner_d;
  logic               game_over_q, game_over_d;
  logic [CntW-1:0]    hold_q, hold_d;
  logic [SCORE_W-1:0] win_score;
  logic [NLIGHTS-1:0] leds;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q   <= '0;
      s2_q   <= '0;
      prev_q <= '0;
    end else begin
      s1_q   <= {bus.key_l, bus.key_r};
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end

  assign press_l = s2_q[1] & ~prev_q[1];
  assign press_r = s2_q[0] & ~prev_q[0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StPlay;
      pos_q       <= PosCtr;
      score_l_q   <= '0;
      score_r_q   <= '0;
      winner_q    <= 2'b00;
      game_over_q <= 1'b0;
      hold_q      <= '0;
    end else begin
      state_q     <= state_d;
      pos_q       <= pos_d;
      score_l_q   <= score_l_d;
      score_r_q   <= score_r_d;
      winner_q    <= winner_d;
      game_over_q <= game_over_d;
      hold_q      <= hold_d;
    end
  end

  assign win_score = winner_q[1] ? score_l_q : score_r_q;

  always_comb begin
    state_d     = state_q;
    pos_d       = pos_q;
    score_l_d   = score_l_q;
    score_r_d   = score_r_q;
    winner_d    = winner_q;
    game_over_d = game_over_q;
    hold_d      = hold_q;
    unique case (state_q)
      StPlay: begin
        // Simultaneous presses cancel: only a lone press acts.
        if (press_l && !press_r) begin
          if (pos_q == PosMax) begin
            if (score_l_q < ScoreMax) score_l_d = score_l_q + SCORE_W'(1);
            winner_d = 2'b10;
            hold_d   = '0;
            state_d  = StWinHold;
          end else begin
            pos_d = pos_q + PosW'(1);
          end
        end else if (press_r && !press_l) begin
          if (pos_q == '0) begin
            if (score_r_q < ScoreMax) score_r_d = score_r_q + SCORE_W'(1);
            winner_d = 2'b01;
            hold_d   = '0;
            state_d  = StWinHold;
          end else begin
            pos_d = pos_q - PosW'(1);
          end
        end
      end
      StWinHold: begin
        if (hold_q == HoldLast) begin
          if (win_score == ScoreMax) begin
            state_d     = StOver;
            game_over_d = 1'b1;
          end else begin
            pos_d    = PosCtr;
            winner_d = 2'b00;
            state_d  = StPlay;
          end
        end else begin
          hold_d = hold_q + CntW'(1);
        end
      end
      StOver: begin
        // Terminal until reset.
      end
      default: state_d = StPlay;
    endcase
  end

  // Lights only show the rope during play; dark during win display and game over.
  always_comb begin
    leds = '0;
    if (state_q == StPlay) leds = NLIGHTS'(1) << pos_q;
  end

  assign bus.leds      = leds;
  assign bus.score_l   = score_l_q;
  assign bus.score_r   = score_r_q;
  assign bus.winner    = winner_q;
  assign bus.game_over = game_over_q;

endmodule

// File: tb/tb_tug_game_ctrl.sv
// Self-checking bench for tug_game_ctrl: vector table, hand-written corner sequences and
// random key activity, all checked against a behavioural model of the game rules.
module tb_tug_game_ctrl;

  localparam int unsigned NL   = 9;
  localparam int unsigned SMAX = 7;
  localparam int unsigned SW   = 3;
  localparam int unsigned HOLD = 4;
  localparam int unsigned C    = (NL - 1) / 2;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  tug_game_ctrl_if #(.NLIGHTS(NL), .SCORE_W(SW)) bus ();

  tug_game_ctrl #(
    .NLIGHTS    (NL),
    .SCORE_MAX  (SMAX),
    .SCORE_W    (SW),
    .HOLD_CYCLES(HOLD)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A press takes effect at the edge two samples after the key is first seen high
  // (key seen 2 samples back = 1, 3 samples back = 0).
  int m_pos, m_sl, m_sr, m_win, m_hold_left;
  bit m_over;
  bit kh_l[3];
  bit kh_r[3];

  task automatic model_reset();
    m_pos = C; m_sl = 0; m_sr = 0; m_win = 0; m_hold_left = 0; m_over = 1'b0;
    for (int i = 0; i < 3; i++) begin kh_l[i] = 1'b0; kh_r[i] = 1'b0; end
  endtask

  task automatic model_step(input bit kl, input bit kr);
    bit pl, pr;
    pl = kh_l[1] & ~kh_l[2];
    pr = kh_r[1] & ~kh_r[2];
    kh_l[2] = kh_l[1]; kh_l[1] = kh_l[0]; kh_l[0] = kl;
    kh_r[2] = kh_r[1]; kh_r[1] = kh_r[0]; kh_r[0] = kr;
    if (m_over) begin
      // frozen
    end else if (m_hold_left > 0) begin
      m_hold_left--;
      if (m_hold_left == 0) begin
        if (((m_win == 2) ? m_sl : m_sr) == SMAX) m_over = 1'b1;
        else begin m_pos = C; m_win = 0; end
      end
    end else if (pl && !pr) begin
      if (m_pos == NL - 1) begin
        m_sl = (m_sl < SMAX) ? m_sl + 1 : m_sl;
        m_win = 2; m_hold_left = HOLD;
      end else m_pos++;
    end else if (pr && !pl) begin
      if (m_pos == 0) begin
        m_sr = (m_sr < SMAX) ? m_sr + 1 : m_sr;
        m_win = 1; m_hold_left = HOLD;
      end else m_pos--;
    end
  endtask

  function automatic logic [31:0] pack(input logic [NL-1:0] l, input logic [SW-1:0] sl,
                                       input logic [SW-1:0] sr, input logic [1:0] w,
                                       input logic go);
    return {14'd0, l, sl, sr, w, go};
  endfunction

  function automatic logic [31:0] model_obs();
    logic [NL-1:0] l;
    l = (m_over || m_hold_left > 0) ? '0 : (NL'(1) << m_pos);
    return pack(l, SW'(m_sl), SW'(m_sr), 2'(m_win), m_over);
  endfunction

  function automatic logic [31:0] dut_obs();
    return pack(bus.leds, bus.score_l, bus.score_r, bus.winner, bus.game_over);
  endfunction

  // ---------------- stimulus helpers (each starts and ends near a negedge) ----------------
  task automatic cycle(input bit kl, input bit kr);
    bus.key_l = kl;
    bus.key_r = kr;
    @(posedge clk);
    model_step(kl, kr);
    @(negedge clk);
    chk("model", dut_obs(), model_obs());
  endtask

  task automatic reset_pulse(input string name);
    reset = 1'b0;
    #1;
    model_reset();
    chk(name, dut_obs(), pack(9'h010, 3'd0, 3'd0, 2'b00, 1'b0));
    #2;
    reset = 1'b1;
  endtask

  task automatic press(input bit left);
    cycle(left, !left);
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
  endtask

  // Counts dark cycles starting with the current observation.
  task automatic hold_dwell(input string name);
    int n;
    n = 0;
    while (bus.leds == '0 && n < 20) begin
      n++;
      cycle(1'b0, 1'b0);
    end
    chk(name, n, HOLD);
  endtask

  typedef struct {
    bit            kl;
    bit            kr;
    logic [NL-1:0] leds;
  } vec_t;

  vec_t tbl[24];

  task automatic set_vec(input int i, input bit kl, input bit kr, input logic [NL-1:0] l);
    tbl[i].kl = kl; tbl[i].kr = kr; tbl[i].leds = l;
  endtask

  bit rkl, rkr;

  initial begin
    bus.key_l = 1'b0;
    bus.key_r = 1'b0;
    model_reset();

    // Held key: moves once, 3 edges after rise; then a single right press back.
    for (int i = 0; i < 10; i++) set_vec(i, 1'b1, 1'b0, (i < 2) ? 9'h010 : 9'h020);
    set_vec(10, 1'b0, 1'b0, 9'h020);
    set_vec(11, 1'b0, 1'b1, 9'h020);
    set_vec(12, 1'b0, 1'b0, 9'h020);
    set_vec(13, 1'b0, 1'b0, 9'h010);
    set_vec(14, 1'b0, 1'b0, 9'h010);
    // Simultaneous presses cancel.
    set_vec(15, 1'b1, 1'b1, 9'h010);
    for (int i = 16; i < 19; i++) set_vec(i, 1'b0, 1'b0, 9'h010);
    // Offset presses: left then right, net no move.
    set_vec(19, 1'b1, 1'b0, 9'h010);
    set_vec(20, 1'b0, 1'b1, 9'h010);
    set_vec(21, 1'b0, 1'b0, 9'h020);
    set_vec(22, 1'b0, 1'b0, 9'h010);
    set_vec(23, 1'b0, 1'b0, 9'h010);

    // 1. Reset state and idle hold.
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset_pulse("reset_state");
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0);
      chk("idle_after_reset", dut_obs(), pack(9'h010, 3'd0, 3'd0, 2'b00, 1'b0));
    end

    // 2./3. Table vectors.
    for (int i = 0; i < 24; i++) begin
      cycle(tbl[i].kl, tbl[i].kr);
      chk($sformatf("vec%0d", i), dut_obs(), pack(tbl[i].leds, 3'd0, 3'd0, 2'b00, 1'b0));
    end

    // 4. Left round win and right mirror.
    repeat (4) press(1'b1);
    chk("left_edge", 32'(bus.leds), 32'(9'h100));
    press(1'b1);
    chk("left_win", dut_obs(), pack(9'h000, 3'd1, 3'd0, 2'b10, 1'b0));
    hold_dwell("left_hold_len");
    chk("left_restart", dut_obs(), pack(9'h010, 3'd1, 3'd0, 2'b00, 1'b0));
    repeat (4) press(1'b0);
    chk("right_edge", 32'(bus.leds), 32'(9'h001));
    press(1'b0);
    chk("right_win", dut_obs(), pack(9'h000, 3'd1, 3'd1, 2'b01, 1'b0));
    hold_dwell("right_hold_len");
    chk("right_restart", dut_obs(), pack(9'h010, 3'd1, 3'd1, 2'b00, 1'b0));

    // 5. Left takes the game.
    for (int r = 0; r < 6; r++) begin
      repeat (5) press(1'b1);
      repeat (HOLD) cycle(1'b0, 1'b0);
    end
    chk("game_over", dut_obs(), pack(9'h000, 3'd7, 3'd1, 2'b10, 1'b1));
    repeat (3) press(1'b1);
    repeat (3) press(1'b0);
    cycle(1'b1, 1'b1);
    repeat (4) cycle(1'b0, 1'b0);
    chk("over_frozen", dut_obs(), pack(9'h000, 3'd7, 3'd1, 2'b10, 1'b1));
    reset_pulse("reset_from_over");

    // 6. Reset in the 2nd hold cycle with key_r held across release.
    repeat (5) press(1'b1);
    cycle(1'b0, 1'b0);
    bus.key_r = 1'b1;
    reset_pulse("reset_in_hold");
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b1);
    chk("held_key_wait", dut_obs(), pack(9'h010, 3'd0, 3'd0, 2'b00, 1'b0));
    cycle(1'b0, 1'b1);
    chk("held_key_move", dut_obs(), pack(9'h008, 3'd0, 3'd0, 2'b00, 1'b0));
    repeat (5) cycle(1'b0, 1'b1);
    chk("held_key_once", dut_obs(), pack(9'h008, 3'd0, 3'd0, 2'b00, 1'b0));
    cycle(1'b0, 1'b0);

    // Random play against the model; left presses more often so games finish.
    reset_pulse("reset_random");
    rkl = 1'b0;
    rkr = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 599) == 0) reset_pulse("reset_random_mid");
      if ($urandom_range(0, 2) == 0) rkl = ~rkl;
      if ($urandom_range(0, 5) == 0) rkr = ~rkr;
      cycle(rkl, rkr);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
